score_display_sequencer: RTL and testbench
==========================================

Name: score_display_sequencer

Overview:
Sequences the pong score shown on the 4-digit seven-segment display. It counts points for the left and right players as 2-digit BCD values and drives the four digit values that feed the display multiplexer: num3:num2 for the left player, num1:num0 for the right player. It also enforces a post-point hold and detects game over. During game over it blinks the winner's digits.

Parameters:
WIN_SCORE, 11, points needed to win; legal range 1..99.
HOLD_CYCLES, 50_000_000, clk cycles in POINT_HOLD after each scored point; must be at least 1.
BLINK_CYCLES, 12_500_000, clk cycles per blink half-period in GAME_OVER; must be at least 1.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
point_l  in  1  single-cycle pulse: left player scored
point_r  in  1  single-cycle pulse: right player scored
new_game  in  1  single-cycle pulse: clear scores and restart
num3  out  4  left score, tens digit (BCD)
num2  out  4  left score, ones digit (BCD)
num1  out  4  right score, tens digit (BCD)
num0  out  4  right score, ones digit (BCD)
blank  out  4  per-digit blank mask, bit i applies to num_i; 1 = top level drives the digit dark
serve_ready  out  1  1 when the game logic may serve the ball
game_over  out  1  1 while in GAME_OVER
winner  out  1  0 = left won, 1 = right won; valid only while game_over = 1

Behaviour:
- Reset values, taken on the clk edge with rst = 1: all scores 0, blank = 4'b0000, state PLAY, serve_ready = 1, game_over = 0, winner = 0, hold and blink counters cleared.
- rst overrides every other input. Reset in any state or mid-count returns to the reset values on that edge.
- All outputs are registered. A point pulse at edge N is visible on num*/serve_ready after edge N.
- State PLAY:
  - point_l increments the left score; point_r increments the right score.
  - If both arrive in the same cycle, left wins priority and point_r is dropped.
  - After incrementing: if the new score equals WIN_SCORE, go to GAME_OVER and set winner accordingly. Otherwise go to POINT_HOLD with serve_ready = 0 and the hold counter loaded.
- State POINT_HOLD:
  - All point pulses are ignored.
  - The counter counts HOLD_CYCLES edges, then the state returns to PLAY with serve_ready = 1.
  - serve_ready is low for exactly HOLD_CYCLES cycles.
- State GAME_OVER:
  - serve_ready = 0 and game_over = 1. Point pulses are ignored and scores are frozen.
  - The blink phase starts visible on entry and toggles every BLINK_CYCLES cycles.
  - While the phase is dark, the winner's two blank bits are 1 (left → 4'b1100, right → 4'b0011). The loser's digits stay lit.
- new_game, in any state and with rst = 0:
  - Clears both scores, blank, winner and game_over; sets serve_ready = 1; state goes to PLAY.
  - It has priority over any point pulse in the same cycle.
- BCD increment:
  - Ones digit 9 → 0 with the tens digit +1, so 09 → 10 and 19 → 20.
  - Digit values are always 0..9.
  - The comparison against WIN_SCORE is done on the BCD pair, using a constant converted at elaboration (tens = WIN_SCORE/10, ones = WIN_SCORE%10).
  - Scores can never exceed WIN_SCORE, so there is no 99 → 00 wrap.
- Counters are sized with $clog2 of their parameter. No counter wraps silently; each reloads on state entry.

Decomposition:
- Package pong_pkg:
  - state enum {PLAY, POINT_HOLD, GAME_OVER} (2 bits);
  - typedef bcd2_t, a struct of tens and ones, each 4 bits;
  - function bcd2_inc;
  - constant SIDE_LEFT = 0, SIDE_RIGHT = 1.
- One sub-module, bcd2_counter: a 2-digit BCD register with inc and clr inputs and a match-to-constant output. It is instantiated twice, once per player.
- The FSM, hold counter and blink timer stay in the top module.

Test Plan:
All scenarios use WIN_SCORE=3, HOLD_CYCLES=4, BLINK_CYCLES=8.
1. Reset, then a point_l pulse → num3:num2 = 0:1, num1:num0 = 0:0. serve_ready is 0 for exactly 4 cycles, then 1.
2. point_l pulsed on every cycle during POINT_HOLD → score stays 01. After the hold ends, one more pulse gives 02.
3. point_l and point_r in the same cycle in PLAY → left = 01, right = 00.
4. Run with WIN_SCORE=12: pulse the right player 10 times with holds between → num1:num0 reads 0:9 then 1:0.
5. Right player reaches 3 → game_over = 1, winner = 1, serve_ready = 0. blank is 0000 for 8 cycles, then 0011 for 8, repeating. Further point_r pulses leave the score at 03.
6. new_game during GAME_OVER, together with point_l → all digits 0, blank = 0000, game_over = 0, serve_ready = 1 on the next cycle. Assert rst mid-POINT_HOLD → reset values on the next edge.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and helpers for the pong score sequencer: FSM states,
// 2-digit BCD score type and BCD arithmetic.
package pong_pkg;

  typedef enum logic [1:0] {
    PLAY       = 2'd0,
    POINT_HOLD = 2'd1,
    GAME_OVER  = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  localparam logic SIDE_LEFT  = 1'b0;
  localparam logic SIDE_RIGHT = 1'b1;

  function automatic bcd2_t bcd2_inc(input bcd2_t v);
    bcd2_t r;
    if (v.ones == 4'd9) begin
      r.ones = 4'd0;
      r.tens = (v.tens == 4'd9) ? 4'd0 : v.tens + 4'd1;
    end else begin
      r.ones = v.ones + 4'd1;
      r.tens = v.tens;
    end
    return r;
  endfunction

  // Binary to BCD pair; used only on elaboration-time constants.
  function automatic bcd2_t to_bcd2(input int unsigned v);
    bcd2_t r;
    r.tens = 4'((v / 32'd10) % 32'd10);
    r.ones = 4'(v % 32'd10);
    return r;
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD score register with increment, clear and a flag telling
// whether the next increment lands on the MATCH constant.
module bcd2_counter
  import pong_pkg::*;
#(
  parameter int unsigned MATCH = 11
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,
  input  logic  inc,
  output bcd2_t value,
  output logic  match
);

  localparam bcd2_t MATCH_BCD = to_bcd2(MATCH);

  bcd2_t value_r;

  // Score register: reset/clear to 00, otherwise BCD increment on request.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value_r <= bcd2_t'(8'h00);
    end else if (inc) begin
      value_r <= bcd2_inc(value_r);
    end
  end

  assign value = value_r;
  assign match = (bcd2_inc(value_r) == MATCH_BCD);

endmodule

// File: rtl/score_display_sequencer.sv
// Pong score sequencer: per-player BCD scores, post-point serve hold,
// game-over detection and winner blinking on the 4-digit display.
module score_display_sequencer
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE    = 11,
  parameter int unsigned HOLD_CYCLES  = 50_000_000,
  parameter int unsigned BLINK_CYCLES = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       point_l,
  input  logic       point_r,
  input  logic       new_game,
  output logic [3:0] num3,
  output logic [3:0] num2,
  output logic [3:0] num1,
  output logic [3:0] num0,
  output logic [3:0] blank,
  output logic       serve_ready,
  output logic       game_over,
  output logic       winner
);

  localparam int unsigned HOLD_W  = (HOLD_CYCLES > 32'd1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned BLINK_W = (BLINK_CYCLES > 32'd1) ? $clog2(BLINK_CYCLES) : 1;

  localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 32'd1);
  localparam logic [HOLD_W-1:0]  HOLD_ZERO  = HOLD_W'(32'd0);
  localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(32'd1);
  localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(BLINK_CYCLES - 32'd1);
  localparam logic [BLINK_W-1:0] BLINK_ZERO = BLINK_W'(32'd0);
  localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(32'd1);

  state_t             state_r, state_s;
  logic [HOLD_W-1:0]  hold_cnt_r, hold_cnt_s;
  logic [BLINK_W-1:0] blink_cnt_r, blink_cnt_s;
  logic               dark_r, dark_s;
  logic               winner_r, winner_s;
  logic               serve_ready_r, serve_ready_s;
  logic               game_over_r, game_over_s;
  logic [3:0]         blank_r, blank_s;
  logic               inc_l_s, inc_r_s, clr_s;
  logic               match_l_s, match_r_s;
  bcd2_t              score_l_s, score_r_s;

  bcd2_counter #(.MATCH(WIN_SCORE)) u_score_l (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_s),
    .inc   (inc_l_s),
    .value (score_l_s),
    .match (match_l_s)
  );

  bcd2_counter #(.MATCH(WIN_SCORE)) u_score_r (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_s),
    .inc   (inc_r_s),
    .value (score_r_s),
    .match (match_r_s)
  );

  // Next-state, counter and registered-output decode; outputs follow the next state.
  always_comb begin
    state_s     = state_r;
    hold_cnt_s  = hold_cnt_r;
    blink_cnt_s = blink_cnt_r;
    dark_s      = dark_r;
    winner_s    = winner_r;
    inc_l_s     = 1'b0;
    inc_r_s     = 1'b0;
    clr_s       = 1'b0;
    blank_s     = 4'b0000;
    if (new_game) begin
      clr_s       = 1'b1;
      state_s     = PLAY;
      hold_cnt_s  = HOLD_ZERO;
      blink_cnt_s = BLINK_ZERO;
      dark_s      = 1'b0;
      winner_s    = SIDE_LEFT;
    end else begin
      case (state_r)
        PLAY: begin
          // Left has priority; a simultaneous right point is dropped.
          if (point_l) begin
            inc_l_s = 1'b1;
            if (match_l_s) begin
              state_s     = GAME_OVER;
              winner_s    = SIDE_LEFT;
              blink_cnt_s = BLINK_LOAD;
              dark_s      = 1'b0;
            end else begin
              state_s    = POINT_HOLD;
              hold_cnt_s = HOLD_LOAD;
            end
          end else if (point_r) begin
            inc_r_s = 1'b1;
            if (match_r_s) begin
              state_s     = GAME_OVER;
              winner_s    = SIDE_RIGHT;
              blink_cnt_s = BLINK_LOAD;
              dark_s      = 1'b0;
            end else begin
              state_s    = POINT_HOLD;
              hold_cnt_s = HOLD_LOAD;
            end
          end else begin
            state_s = PLAY;
          end
        end
        POINT_HOLD: begin
          if (hold_cnt_r == HOLD_ZERO) begin
            state_s = PLAY;
          end else begin
            hold_cnt_s = hold_cnt_r - HOLD_ONE;
          end
        end
        GAME_OVER: begin
          if (blink_cnt_r == BLINK_ZERO) begin
            dark_s      = ~dark_r;
            blink_cnt_s = BLINK_LOAD;
          end else begin
            blink_cnt_s = blink_cnt_r - BLINK_ONE;
          end
        end
        default: begin
          state_s = PLAY;
        end
      endcase
    end
    serve_ready_s = (state_s == PLAY);
    game_over_s   = (state_s == GAME_OVER);
    if (game_over_s && dark_s) begin
      blank_s = (winner_s == SIDE_RIGHT) ? 4'b0011 : 4'b1100;
    end else begin
      blank_s = 4'b0000;
    end
  end

  // State, counters and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= PLAY;
      hold_cnt_r    <= HOLD_ZERO;
      blink_cnt_r   <= BLINK_ZERO;
      dark_r        <= 1'b0;
      winner_r      <= SIDE_LEFT;
      serve_ready_r <= 1'b1;
      game_over_r   <= 1'b0;
      blank_r       <= 4'b0000;
    end else begin
      state_r       <= state_s;
      hold_cnt_r    <= hold_cnt_s;
      blink_cnt_r   <= blink_cnt_s;
      dark_r        <= dark_s;
      winner_r      <= winner_s;
      serve_ready_r <= serve_ready_s;
      game_over_r   <= game_over_s;
      blank_r       <= blank_s;
    end
  end

  assign num3        = score_l_s.tens;
  assign num2        = score_l_s.ones;
  assign num1        = score_r_s.tens;
  assign num0        = score_r_s.ones;
  assign blank       = blank_r;
  assign serve_ready = serve_ready_r;
  assign game_over   = game_over_r;
  assign winner      = winner_r;

endmodule

// File: tb/tb_score_display_sequencer.sv
// Directed scoreboard bench: dut_a (WIN=3, HOLD=4, BLINK=8) and dut_b (WIN=12).
module tb_score_display_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, point_l, point_r, new_game;
  logic point_l_b, point_r_b, new_game_b;
  logic [3:0] num3_a, num2_a, num1_a, num0_a, blank_a;
  logic serve_ready_a, game_over_a, winner_a;
  logic [3:0] num3_b, num2_b, num1_b, num0_b, blank_b;
  logic serve_ready_b, game_over_b, winner_b;

  score_display_sequencer #(.WIN_SCORE(3), .HOLD_CYCLES(4), .BLINK_CYCLES(8)) dut_a (
    .clk(clk), .rst(rst), .point_l(point_l), .point_r(point_r), .new_game(new_game),
    .num3(num3_a), .num2(num2_a), .num1(num1_a), .num0(num0_a), .blank(blank_a),
    .serve_ready(serve_ready_a), .game_over(game_over_a), .winner(winner_a)
  );

  score_display_sequencer #(.WIN_SCORE(12), .HOLD_CYCLES(4), .BLINK_CYCLES(8)) dut_b (
    .clk(clk), .rst(rst), .point_l(point_l_b), .point_r(point_r_b), .new_game(new_game_b),
    .num3(num3_b), .num2(num2_b), .num1(num1_b), .num0(num0_b), .blank(blank_b),
    .serve_ready(serve_ready_b), .game_over(game_over_b), .winner(winner_b)
  );

  typedef struct packed {
    logic [3:0] n3;
    logic [3:0] n2;
    logic [3:0] n1;
    logic [3:0] n0;
    logic [3:0] bl;
    logic       sr;
    logic       go;
    logic       w;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  function automatic string fmt(exp_t v);
    return $sformatf("%0d%0d:%0d%0d blank=%b serve_ready=%b game_over=%b winner=%b",
                     v.n3, v.n2, v.n1, v.n0, v.bl, v.sr, v.go, v.w);
  endfunction

  // Push expectation, advance one edge, then pop and compare against the selected DUT.
  task automatic step(input string tag, input bit sel_b, input logic [7:0] l, input logic [7:0] r,
                      input logic [3:0] bl, input logic sr, input logic go, input logic w);
    exp_t  e;
    exp_t  obs;
    string t;
    e.n3 = l[7:4]; e.n2 = l[3:0]; e.n1 = r[7:4]; e.n0 = r[3:0];
    e.bl = bl; e.sr = sr; e.go = go; e.w = w;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    point_l = 1'b0; point_r = 1'b0; new_game = 1'b0; point_r_b = 1'b0;
    if (sel_b)
      obs = {num3_b, num2_b, num1_b, num0_b, blank_b, serve_ready_b, game_over_b, winner_b};
    else
      obs = {num3_a, num2_a, num1_a, num0_a, blank_a, serve_ready_a, game_over_a, winner_a};
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed %s expected %s", t, fmt(obs), fmt(e));
    end
  endtask

  task automatic sa(input string tag, input logic [7:0] l, input logic [7:0] r,
                    input logic [3:0] bl, input logic sr, input logic go, input logic w);
    step(tag, 1'b0, l, r, bl, sr, go, w);
  endtask

  task automatic sb(input string tag, input logic [7:0] l, input logic [7:0] r,
                    input logic [3:0] bl, input logic sr, input logic go, input logic w);
    step(tag, 1'b1, l, r, bl, sr, go, w);
  endtask

  initial begin
    logic [7:0] bcd_k;
    rst = 1'b1; point_l = 1'b0; point_r = 1'b0; new_game = 1'b0;
    point_l_b = 1'b0; point_r_b = 1'b0; new_game_b = 1'b0;

    sa("reset_a", 8'h00, 8'h00, 4'b0000, 1'b1, 1'b0, 1'b0);
    sb("reset_b", 8'h00, 8'h00, 4'b0000, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;

    // WIN=12: right player through 09 -> 10 and on to the win.
    for (int k = 1; k <= 12; k++) begin
      bcd_k = 8'(((k / 10) << 4) + (k % 10));
      point_r_b = 1'b1;
      if (k < 12) begin
        sb("b_point", 8'h00, bcd_k, 4'b0000, 1'b0, 1'b0, 1'b0);
        repeat (3) sb("b_hold", 8'h00, bcd_k, 4'b0000, 1'b0, 1'b0, 1'b0);
        sb("b_release", 8'h00, bcd_k, 4'b0000, 1'b1, 1'b0, 1'b0);
      end else begin
        sb("b_win", 8'h00, bcd_k, 4'b0000, 1'b0, 1'b1, 1'b1);
      end
    end
    point_r_b = 1'b1;
    sb("b_frozen", 8'h00, 8'h12, 4'b0000, 1'b0, 1'b1, 1'b1);

    // Single left point and exact hold length.
    point_l = 1'b1;
    sa("s1_point", 8'h01, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0);
    repeat (3) sa("s1_hold", 8'h01, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0);
    sa("s1_release", 8'h01, 8'h00, 4'b0000, 1'b1, 1'b0, 1'b0);

    // Simultaneous points: left wins priority.
    point_l = 1'b1; point_r = 1'b1;
    sa("s3_both", 8'h02, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Pulses on every hold cycle are ignored.
    for (int i = 0; i < 3; i++) begin
      point_l = 1'b1; point_r = 1'b1;
      sa("s2_ignored", 8'h02, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0);
    end
    point_l = 1'b1; point_r = 1'b1;
    sa("s2_hold_end", 8'h02, 8'h00, 4'b0000, 1'b1, 1'b0, 1'b0);

    // Left reaches 3: blink left digits.
    point_l = 1'b1;
    sa("left_win", 8'h03, 8'h00, 4'b0000, 1'b0, 1'b1, 1'b0);
    repeat (7) sa("left_vis", 8'h03, 8'h00, 4'b0000, 1'b0, 1'b1, 1'b0);
    repeat (8) sa("left_dark", 8'h03, 8'h00, 4'b1100, 1'b0, 1'b1, 1'b0);
    sa("left_vis2", 8'h03, 8'h00, 4'b0000, 1'b0, 1'b1, 1'b0);

    new_game = 1'b1; point_l = 1'b1;
    sa("new_game_left", 8'h00, 8'h00, 4'b0000, 1'b1, 1'b0, 1'b0);

    // Right reaches 3 with holds between points.
    for (int k = 1; k <= 2; k++) begin
      bcd_k = 8'(k);
      point_r = 1'b1;
      sa("r_point", 8'h00, bcd_k, 4'b0000, 1'b0, 1'b0, 1'b0);
      repeat (3) sa("r_hold", 8'h00, bcd_k, 4'b0000, 1'b0, 1'b0, 1'b0);
      sa("r_release", 8'h00, bcd_k, 4'b0000, 1'b1, 1'b0, 1'b0);
    end
    point_r = 1'b1;
    sa("r_win", 8'h00, 8'h03, 4'b0000, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      point_r = 1'b1;
      sa("r_vis_frozen", 8'h00, 8'h03, 4'b0000, 1'b0, 1'b1, 1'b1);
    end
    repeat (8) sa("r_dark", 8'h00, 8'h03, 4'b0011, 1'b0, 1'b1, 1'b1);
    repeat (8) sa("r_vis", 8'h00, 8'h03, 4'b0000, 1'b0, 1'b1, 1'b1);
    sa("r_dark2", 8'h00, 8'h03, 4'b0011, 1'b0, 1'b1, 1'b1);

    new_game = 1'b1; point_l = 1'b1;
    sa("new_game_over", 8'h00, 8'h00, 4'b0000, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of a hold.
    point_l = 1'b1;
    sa("pre_rst", 8'h01, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0);
    sa("pre_rst_hold", 8'h01, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0);
    rst = 1'b1; point_l = 1'b1;
    sa("rst_mid_hold", 8'h00, 8'h00, 4'b0000, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    point_r = 1'b1;
    sa("post_rst_point", 8'h00, 8'h01, 4'b0000, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
